// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the hazard scoreboard: packets, forwarding selects
// and the hard-wired zero register.
package hazard_scoreboard_pkg;

   localparam int unsigned REG_W = 5;
   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef enum logic [4:0] {
      RS_IS_RS    = 5'd0,
      RS_IS_EX_0  = 5'd1,
      RS_IS_EX_1  = 5'd2,
      RS_IS_EX_2  = 5'd3,
      RS_IS_EX_3  = 5'd4,
      RS_IS_EX_4  = 5'd5,
      RS_IS_EX_5  = 5'd6,
      RS_IS_EX_6  = 5'd7,
      RS_IS_EX_7  = 5'd8,
      RS_IS_MEM_0 = 5'd9,
      RS_IS_MEM_1 = 5'd10,
      RS_IS_MEM_2 = 5'd11,
      RS_IS_MEM_3 = 5'd12,
      RS_IS_MEM_4 = 5'd13,
      RS_IS_MEM_5 = 5'd14,
      RS_IS_MEM_6 = 5'd15,
      RS_IS_MEM_7 = 5'd16
   } rs_select_e;

   localparam logic [4:0] SEL_EX_BASE  = 5'd1;
   localparam logic [4:0] SEL_MEM_BASE = 5'd9;

   typedef struct packed {
      logic             valid;
      logic             rd_mem;
      logic [REG_W-1:0] rs1_idx;
      logic [REG_W-1:0] rs2_idx;
      logic [REG_W-1:0] dest_reg_idx;
      rs_select_e       rs1_select;
      rs_select_e       rs2_select;
   } id_ex_packet_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest_reg_idx;
   } ex_mem_packet_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_select.sv
// Per-operand forwarding priority encoder: youngest EX producer, then youngest
// MEM producer, otherwise the register file.
module hazard_scoreboard_fwd_select
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned WAYS = 3
) (
   input  logic [REG_W-1:0]            src,
   input  logic [WAYS-1:0][REG_W-1:0]  ex_dest,
   input  logic [WAYS-1:0]             ex_valid,
   input  logic [WAYS-1:0][REG_W-1:0]  mem_dest,
   input  logic [WAYS-1:0]             mem_valid,
   output rs_select_e                  sel
);

   // Later assignments override earlier ones, so EX beats MEM and high ways win.
   always_comb begin
      sel = RS_IS_RS;
      if (src != ZERO_REG) begin
         for (int w = 0; w < WAYS; w++) begin
            if (mem_valid[w] && mem_dest[w] == src) sel = rs_select_e'(SEL_MEM_BASE + 5'(w));
         end
         for (int w = 0; w < WAYS; w++) begin
            if (ex_valid[w] && ex_dest[w] == src) sel = rs_select_e'(SEL_EX_BASE + 5'(w));
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// N-way hazard/forwarding unit: per-register load countdown scoreboard decides how
// many leading ways may issue; operand selects are rewritten for forwarding.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned WAYS     = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned NREG     = 32,
   localparam int unsigned CNT_W   = $clog2(LOAD_LAT + 1),
   localparam int unsigned IC_W    = $clog2(WAYS + 1)
) (
   input  logic           clock,
   input  logic           reset,
   input  id_ex_packet_t  id_packet [WAYS],
   input  id_ex_packet_t  ex_packet [WAYS],
   input  ex_mem_packet_t mem_packet [WAYS],
   input  logic           mem_stall,
   input  logic           squash,
   output id_ex_packet_t  id_packet_out [WAYS],
   output logic [IC_W-1:0] issue_count,
   output logic [31:0]    stall_cycles
);

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [31:0]      stall_q, stall_d;

   logic [WAYS-1:0][REG_W-1:0] ex_dest, mem_dest;
   logic [WAYS-1:0]            ex_valid, mem_valid;
   logic [WAYS-1:0]            blocked;
   rs_select_e                 rs1_sel [WAYS];
   rs_select_e                 rs2_sel [WAYS];
   logic                       unused_ex_fields;

   always_comb begin
      unused_ex_fields = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         ex_dest[w]   = ex_packet[w].dest_reg_idx;
         ex_valid[w]  = ex_packet[w].valid;
         mem_dest[w]  = mem_packet[w].dest_reg_idx;
         mem_valid[w] = mem_packet[w].valid;
         unused_ex_fields ^= ^{ex_packet[w].rd_mem, ex_packet[w].rs1_idx, ex_packet[w].rs2_idx,
                               ex_packet[w].rs1_select, ex_packet[w].rs2_select};
      end
   end

   for (genvar j = 0; j < WAYS; j++) begin : g_way
      hazard_scoreboard_fwd_select #(.WAYS(WAYS)) u_rs1_sel (
         .src       (id_packet[j].rs1_idx),
         .ex_dest   (ex_dest),
         .ex_valid  (ex_valid),
         .mem_dest  (mem_dest),
         .mem_valid (mem_valid),
         .sel       (rs1_sel[j])
      );
      hazard_scoreboard_fwd_select #(.WAYS(WAYS)) u_rs2_sel (
         .src       (id_packet[j].rs2_idx),
         .ex_dest   (ex_dest),
         .ex_valid  (ex_valid),
         .mem_dest  (mem_dest),
         .mem_valid (mem_valid),
         .sel       (rs2_sel[j])
      );
   end

   always_comb begin
      for (int j = 0; j < WAYS; j++) begin
         id_packet_out[j]            = id_packet[j];
         id_packet_out[j].rs1_select = reset ? RS_IS_RS : rs1_sel[j];
         id_packet_out[j].rs2_select = reset ? RS_IS_RS : rs2_sel[j];
      end
   end

   // A way is blocked by a pending load source or by an older in-bundle writer.
   always_comb begin
      for (int j = 0; j < WAYS; j++) begin
         blocked[j] = mem_stall;
         if (id_packet[j].rs1_idx != ZERO_REG && cnt_q[id_packet[j].rs1_idx] != '0) blocked[j] = 1'b1;
         if (id_packet[j].rs2_idx != ZERO_REG && cnt_q[id_packet[j].rs2_idx] != '0) blocked[j] = 1'b1;
         for (int i = 0; i < j; i++) begin
            if (id_packet[i].valid && id_packet[i].dest_reg_idx != ZERO_REG &&
                (id_packet[i].dest_reg_idx == id_packet[j].rs1_idx ||
                 id_packet[i].dest_reg_idx == id_packet[j].rs2_idx)) begin
               blocked[j] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      issue_count = IC_W'(WAYS);
      for (int j = int'(WAYS) - 1; j >= 0; j--) begin
         if (blocked[j]) issue_count = IC_W'(j);
      end
      if (reset) issue_count = '0;
   end

   // Countdown first, then accepted writers in ascending way order overwrite it.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = (!mem_stall && cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : cnt_q[r];
      end
      if (!squash) begin
         for (int k = 0; k < WAYS; k++) begin
            if (IC_W'(k) < issue_count && id_packet[k].dest_reg_idx != ZERO_REG &&
                int'(id_packet[k].dest_reg_idx) < int'(NREG)) begin
               cnt_d[id_packet[k].dest_reg_idx] = id_packet[k].rd_mem ? CNT_W'(LOAD_LAT) : '0;
            end
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (issue_count < IC_W'(WAYS) && stall_q != '1) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
         stall_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: two instances (LOAD_LAT 1 and 2) share
// one stimulus stream; each step checks hand-computed issue counts and selects.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   logic           clock = 1'b0;
   logic           reset;
   logic           mem_stall;
   logic           squash;
   id_ex_packet_t  id_pkt  [3];
   id_ex_packet_t  ex_pkt  [3];
   ex_mem_packet_t mem_pkt [3];
   id_ex_packet_t  out1 [3];
   id_ex_packet_t  out2 [3];
   logic [1:0]     ic1, ic2;
   logic [31:0]    sc1, sc2;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   hazard_scoreboard #(.WAYS(3), .LOAD_LAT(1), .NREG(32)) dut1 (
      .clock         (clock),
      .reset         (reset),
      .id_packet     (id_pkt),
      .ex_packet     (ex_pkt),
      .mem_packet    (mem_pkt),
      .mem_stall     (mem_stall),
      .squash        (squash),
      .id_packet_out (out1),
      .issue_count   (ic1),
      .stall_cycles  (sc1)
   );

   hazard_scoreboard #(.WAYS(3), .LOAD_LAT(2), .NREG(32)) dut2 (
      .clock         (clock),
      .reset         (reset),
      .id_packet     (id_pkt),
      .ex_packet     (ex_pkt),
      .mem_packet    (mem_pkt),
      .mem_stall     (mem_stall),
      .squash        (squash),
      .id_packet_out (out2),
      .issue_count   (ic2),
      .stall_cycles  (sc2)
   );

   function automatic id_ex_packet_t idp(input logic v, input logic ld, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [4:0] rd);
      id_ex_packet_t p;
      p.valid        = v;
      p.rd_mem       = ld;
      p.rs1_idx      = rs1;
      p.rs2_idx      = rs2;
      p.dest_reg_idx = rd;
      p.rs1_select   = RS_IS_RS;
      p.rs2_select   = RS_IS_RS;
      return p;
   endfunction

   function automatic ex_mem_packet_t mp(input logic v, input logic [4:0] rd);
      ex_mem_packet_t p;
      p.valid        = v;
      p.dest_reg_idx = rd;
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int w = 0; w < 3; w++) begin
         id_pkt[w]  = idp(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
         ex_pkt[w]  = idp(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
         mem_pkt[w] = mp(1'b0, 5'd0);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic consumer_bundle();
      clear_inputs();
      id_pkt[0] = idp(1'b1, 1'b0, 5'd3, 5'd0, 5'd14);
      id_pkt[1] = idp(1'b1, 1'b0, 5'd8, 5'd0, 5'd15);
   endtask

   initial begin
      reset = 1'b1;
      mem_stall = 1'b0;
      squash = 1'b0;
      clear_inputs();

      // Reset: issue forced to 0, selects forced to RS even with an EX hit
      next_cycle();
      id_pkt[0] = idp(1'b1, 1'b0, 5'd4, 5'd0, 5'd0);
      ex_pkt[0] = idp(1'b1, 1'b0, 5'd0, 5'd0, 5'd4);
      #1;
      check("reset_issue", 32'(ic1), 32'd0);
      check("reset_sel", 32'(out1[0].rs1_select), 32'(RS_IS_RS));
      next_cycle();
      reset = 1'b0;
      clear_inputs();
      #1;
      check("post_reset_stall1", sc1, 32'd0);
      check("post_reset_stall2", sc2, 32'd0);
      check("idle_issue", 32'(ic1), 32'd3);

      // No hazards
      id_pkt[0] = idp(1'b1, 1'b0, 5'd5, 5'd6, 5'd11);
      id_pkt[1] = idp(1'b1, 1'b0, 5'd7, 5'd5, 5'd12);
      id_pkt[2] = idp(1'b1, 1'b0, 5'd6, 5'd7, 5'd13);
      for (int w = 0; w < 3; w++) begin
         ex_pkt[w]  = idp(1'b1, 1'b0, 5'd0, 5'd0, 5'(w + 1));
         mem_pkt[w] = mp(1'b1, 5'(w + 1));
      end
      #1;
      check("nohaz_issue", 32'(ic1), 32'd3);
      check("nohaz_sel_w0", 32'(out1[0].rs1_select), 32'(RS_IS_RS));
      check("nohaz_sel_w2", 32'(out1[2].rs2_select), 32'(RS_IS_RS));
      next_cycle();
      clear_inputs();
      #1;
      check("nohaz_stall", sc1, 32'd0);

      // Forwarding priority
      id_pkt[1] = idp(1'b1, 1'b0, 5'd4, 5'd0, 5'd22);
      ex_pkt[0] = idp(1'b1, 1'b0, 5'd0, 5'd0, 5'd4);
      ex_pkt[1] = idp(1'b1, 1'b0, 5'd0, 5'd0, 5'd1);
      ex_pkt[2] = idp(1'b1, 1'b0, 5'd0, 5'd0, 5'd4);
      #1;
      check("fwd_ex2", 32'(out1[1].rs1_select), 32'(RS_IS_EX_2));
      check("fwd_x0_rs", 32'(out1[1].rs2_select), 32'(RS_IS_RS));
      mem_pkt[1] = mp(1'b1, 5'd4);
      #1;
      check("fwd_ex_over_mem", 32'(out1[1].rs1_select), 32'(RS_IS_EX_2));
      for (int w = 0; w < 3; w++) ex_pkt[w] = idp(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      mem_pkt[0] = mp(1'b1, 5'd4);
      #1;
      check("fwd_mem1", 32'(out1[1].rs1_select), 32'(RS_IS_MEM_1));
      check("fwd_issue", 32'(ic1), 32'd3);

      // Load-use, LOAD_LAT = 1
      next_cycle();
      clear_inputs();
      id_pkt[0] = idp(1'b1, 1'b1, 5'd2, 5'd0, 5'd8);
      #1;
      check("lu1_load_issue", 32'(ic1), 32'd3);
      next_cycle();
      consumer_bundle();
      #1;
      check("lu1_blocked", 32'(ic1), 32'd1);
      next_cycle();
      mem_pkt[0] = mp(1'b1, 5'd8);
      #1;
      check("lu1_release", 32'(ic1), 32'd3);
      check("lu1_sel_mem0", 32'(out1[1].rs1_select), 32'(RS_IS_MEM_0));
      check("lu2_sel_mem0", 32'(out2[1].rs1_select), 32'(RS_IS_MEM_0));
      check("lu1_stall", sc1, 32'd1);

      // LOAD_LAT = 2 with two mem_stall cycles
      next_cycle();
      clear_inputs();
      reset = 1'b1;
      #1;
      check("rst2_issue", 32'(ic2), 32'd0);
      next_cycle();
      reset = 1'b0;
      id_pkt[0] = idp(1'b1, 1'b1, 5'd2, 5'd0, 5'd8);
      #1;
      check("ms_load_issue", 32'(ic2), 32'd3);
      check("ms_stall0", sc2, 32'd0);
      next_cycle();
      consumer_bundle();
      mem_stall = 1'b1;
      #1;
      check("ms_stall_c1", 32'(ic2), 32'd0);
      next_cycle();
      #1;
      check("ms_stall_c2", 32'(ic2), 32'd0);
      next_cycle();
      mem_stall = 1'b0;
      #1;
      check("ms_block_c3", 32'(ic2), 32'd1);
      next_cycle();
      #1;
      check("ms_block_c4", 32'(ic2), 32'd1);
      next_cycle();
      #1;
      check("ms_release", 32'(ic2), 32'd3);
      check("ms_stall_cycles", sc2, 32'd4);

      // Reset mid-countdown
      next_cycle();
      clear_inputs();
      id_pkt[0] = idp(1'b1, 1'b1, 5'd2, 5'd0, 5'd8);
      next_cycle();
      consumer_bundle();
      #1;
      check("rmc_pending", 32'(ic2), 32'd1);
      reset = 1'b1;
      #1;
      check("rmc_forced", 32'(ic2), 32'd0);
      next_cycle();
      reset = 1'b0;
      #1;
      check("rmc_cleared", 32'(ic2), 32'd3);
      check("rmc_stall", sc2, 32'd0);

      // Intra-bundle RAW
      next_cycle();
      clear_inputs();
      id_pkt[0] = idp(1'b1, 1'b0, 5'd1, 5'd2, 5'd9);
      id_pkt[1] = idp(1'b1, 1'b0, 5'd3, 5'd4, 5'd20);
      id_pkt[2] = idp(1'b1, 1'b0, 5'd9, 5'd0, 5'd21);
      #1;
      check("raw_issue", 32'(ic1), 32'd2);

      // WAW: a younger non-load write cancels the load's pending state
      next_cycle();
      clear_inputs();
      id_pkt[0] = idp(1'b1, 1'b1, 5'd2, 5'd0, 5'd8);
      id_pkt[1] = idp(1'b1, 1'b0, 5'd3, 5'd0, 5'd8);
      #1;
      check("waw_issue", 32'(ic2), 32'd3);
      next_cycle();
      consumer_bundle();
      #1;
      check("waw_reader", 32'(ic2), 32'd3);

      // Squash: issue still computed and counted, nothing committed
      next_cycle();
      clear_inputs();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      squash = 1'b1;
      id_pkt[0] = idp(1'b1, 1'b1, 5'd2, 5'd0, 5'd10);
      id_pkt[1] = idp(1'b1, 1'b0, 5'd10, 5'd0, 5'd16);
      #1;
      check("sq_issue", 32'(ic1), 32'd1);
      next_cycle();
      squash = 1'b0;
      clear_inputs();
      id_pkt[1] = idp(1'b1, 1'b0, 5'd10, 5'd0, 5'd16);
      #1;
      check("sq_reader1", 32'(ic1), 32'd3);
      check("sq_reader2", 32'(ic2), 32'd3);
      check("sq_stall", sc1, 32'd1);

      // x0 never blocks or forwards
      next_cycle();
      clear_inputs();
      ex_pkt[2]  = idp(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      mem_pkt[0] = mp(1'b1, 5'd0);
      id_pkt[0]  = idp(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
      id_pkt[1]  = idp(1'b1, 1'b0, 5'd0, 5'd0, 5'd5);
      #1;
      check("x0_issue", 32'(ic1), 32'd3);
      check("x0_sel", 32'(out1[1].rs1_select), 32'(RS_IS_RS));
      next_cycle();
      #1;
      check("x0_next_issue", 32'(ic2), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
